arb_req_fifo: RTL and testbench

- Per-requester ingress buffer that sits directly upstream of the round-robin arbiter. One instance is used per arbiter input (A, B).
- Accepts words from a producer over a valid/ready handshake and stores them in a DEPTH-entry first-word-fall-through FIFO.
- Presents the head word to the arbiter as valid_o/data_o and pops it when the arbiter grants this port.
- Decouples bursty producers from arbitration latency so the arbiter never sees a dropped request.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_req_fifo_mem.sv | 21 ++
 rtl/arb_req_fifo.sv | 101 ++++++++++
 tb/tb_arb_req_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter ingress path.
package arb_pkg;
  localparam int ARB_DATA_WIDTH = 16;

  typedef logic [ARB_DATA_WIDTH-1:0] arb_data_t;

  localparam arb_data_t ARB_IDLE_A = 16'hA000;
  localparam arb_data_t ARB_IDLE_B = 16'hB000;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int arb_clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/arb_req_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one write port, one asynchronous read port.
module arb_req_fifo_mem #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 8,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/arb_req_fifo.sv
// First-word-fall-through ingress FIFO feeding one arbiter input.
// Define ARB_REQ_FIFO_HWM_EN to add the hwm_o / ovf_attempt_o debug outputs.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter  int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter  int DEPTH      = 8,
  localparam int CNT_W      = arb_clog2_cnt(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  grant_i,
  output logic [CNT_W-1:0]      count_o,
`ifdef ARB_REQ_FIFO_HWM_EN
  output logic [CNT_W-1:0]      hwm_o,
  output logic [1:0]            ovf_attempt_o,
`endif
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("arb_req_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_full, w_empty, w_push, w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Outputs are forced to their idle values for as long as reset is held.
  assign in_ready_o = !w_full && !areset;
  assign valid_o    = !w_empty && !areset;
  assign data_o     = valid_o ? w_rd_data : '0;
  assign count_o    = areset ? '0 : r_cnt;
  assign full_o     = w_full && !areset;
  assign empty_o    = w_empty || areset;

  assign w_push = in_valid_i && in_ready_o;
  assign w_pop  = grant_i && valid_o;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 1'b1;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= w_cnt_nxt;
    end
  end

  arb_req_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .aclk    (aclk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

`ifdef ARB_REQ_FIFO_HWM_EN
  logic [CNT_W-1:0] r_hwm;
  logic             r_ovf;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_hwm <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_cnt_nxt > r_hwm) r_hwm <= w_cnt_nxt;
      if (in_valid_i && w_full) r_ovf <= 1'b1;
    end
  end

  // Bit 0: sticky stall-at-full flag; bit 1: producer stalled at full this cycle.
  assign hwm_o         = r_hwm;
  assign ovf_attempt_o = {in_valid_i && full_o, r_ovf};
`endif
endmodule

// File: tb/tb_arb_req_fifo.sv
// Directed self-checking bench for arb_req_fifo (DEPTH=8, DATA_WIDTH=16).
module tb_arb_req_fifo;
  import arb_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = arb_clog2_cnt(DEPTH);

  logic             aclk = 1'b0;
  logic             areset;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DW-1:0]    in_data_i;
  logic             valid_o;
  logic [DW-1:0]    data_o;
  logic             grant_i;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;
`ifdef ARB_REQ_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_o;
  logic [1:0]       ovf_attempt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 aclk = ~aclk;

  arb_req_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .grant_i    (grant_i),
    .count_o    (count_o),
`ifdef ARB_REQ_FIFO_HWM_EN
    .hwm_o         (hwm_o),
    .ovf_attempt_o (ovf_attempt_o),
`endif
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1; in_valid_i = 1'b0; in_data_i = ARB_IDLE_A; grant_i = 1'b0;
    step(); step();
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data",  32'(data_o),  0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_ready", 32'(in_ready_o), 0);
    chk("rst_full",  32'(full_o), 0);
    areset = 1'b0;
    step();
    chk("post_rst_ready", 32'(in_ready_o), 1);

    // single word
    in_valid_i = 1'b1; in_data_i = 16'hAAAA;
    step();
    in_valid_i = 1'b0; in_data_i = ARB_IDLE_A;
    chk("one_valid", 32'(valid_o), 1);
    chk("one_data",  32'(data_o),  32'hAAAA);
    chk("one_count", 32'(count_o), 1);
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    chk("one_pop_valid", 32'(valid_o), 0);
    chk("one_pop_count", 32'(count_o), 0);
    chk("one_pop_data",  32'(data_o),  0);

    // fill to full
    for (int i = 1; i <= DEPTH; i++) begin
      in_valid_i = 1'b1; in_data_i = DW'(i);
      step();
    end
    chk("fill_count", 32'(count_o), DEPTH);
    chk("fill_full",  32'(full_o), 1);
    chk("fill_ready", 32'(in_ready_o), 0);
    in_data_i = 16'h0009;
    step();
    chk("full_hold_count", 32'(count_o), DEPTH);
    chk("full_hold_head",  32'(data_o), 1);
    // pop at full with the 9th word still offered: no write-through
    grant_i = 1'b1;
    step();
    in_valid_i = 1'b0; in_data_i = ARB_IDLE_A;
    chk("full_pop_count", 32'(count_o), DEPTH - 1);
    chk("full_pop_ready", 32'(in_ready_o), 1);
    for (int i = 2; i <= DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), 32'(data_o), i);
      step();
    end
    grant_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 1);
    chk("drain_valid", 32'(valid_o), 0);

    // steady stream at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = DW'(16'h0100 + i);
      step();
    end
    chk("stream_pre_count", 32'(count_o), 3);
    grant_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      in_data_i = DW'(16'h0103 + k);
      chk($sformatf("stream_data_%0d", k), 32'(data_o), 32'h0100 + k);
      step();
      chk($sformatf("stream_cnt_%0d", k), 32'(count_o), 3);
    end
    in_valid_i = 1'b0;
    for (int k = 24; k < 27; k++) begin
      chk($sformatf("stream_tail_%0d", k), 32'(data_o), 32'h0100 + k);
      step();
    end
    grant_i = 1'b0;
    chk("stream_end_count", 32'(count_o), 0);

    // push + grant while empty: pop ignored
    in_valid_i = 1'b1; in_data_i = 16'hBBBB; grant_i = 1'b1;
    step();
    in_valid_i = 1'b0; grant_i = 1'b0; in_data_i = ARB_IDLE_B;
    chk("empty_both_count", 32'(count_o), 1);
    chk("empty_both_data",  32'(data_o),  32'hBBBB);
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    chk("empty_both_drain", 32'(count_o), 0);

    // reset mid-burst with 5 queued
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_data_i = DW'(16'h0050 + i);
      step();
    end
    in_valid_i = 1'b0;
    chk("pre_rst_count", 32'(count_o), 5);
    chk("pre_rst_head",  32'(data_o),  32'h0050);
`ifdef ARB_REQ_FIFO_HWM_EN
    chk("pre_rst_hwm", 32'(hwm_o), DEPTH);
`endif
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    step();
    chk("after_rst_count", 32'(count_o), 0);
    chk("after_rst_valid", 32'(valid_o), 0);
    chk("after_rst_data",  32'(data_o),  0);
`ifdef ARB_REQ_FIFO_HWM_EN
    chk("after_rst_hwm", 32'(hwm_o), 0);
`endif
    in_valid_i = 1'b1; in_data_i = 16'h0077;
    step();
    in_valid_i = 1'b0;
    chk("after_rst_new_data",  32'(data_o),  32'h0077);
    chk("after_rst_new_count", 32'(count_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
